// File: rtl/butterfly_pair_reader.sv
// butterfly_pair_reader
// Groups a gapped sample stream into (A, B) pairs and queues the pairs in a
// small FIFO for a downstream butterfly that can stall. When a pair arrives
// while the FIFO is full and nothing is leaving, that pair is dropped and a
// sticky overflow flag is raised.
module butterfly_pair_reader #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4     // power of two, >= 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          valid_in,
    input  logic                          flush,
    output logic [WIDTH-1:0]              a_out,
    output logic [WIDTH-1:0]              b_out,
    output logic                          pair_valid,
    input  logic                          pair_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        EXPECT_A = 1'b0,
        EXPECT_B = 1'b1
    } pair_state_t;

    pair_state_t              state;
    pair_state_t              state_next;
    logic                     latch_a;
    logic                     pair_formed;
    logic [WIDTH-1:0]         held_a;

    logic [2*WIDTH-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [2*WIDTH-1:0]       head;
    logic                     pop;
    logic                     push;
    logic                     drop;

    // Pairing state register; flush returns to EXPECT_A like reset does
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EXPECT_A;
        end else if (flush) begin
            state <= EXPECT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next pairing state: advance only on valid samples so gaps are tolerated
    always_comb begin
        state_next = state;
        if (valid_in) begin
            state_next = (state == EXPECT_A) ? EXPECT_B : EXPECT_A;
        end
    end

    // Pairing outputs: capture A, or announce a complete pair on B
    always_comb begin
        latch_a     = 1'b0;
        pair_formed = 1'b0;
        if (valid_in && !flush) begin
            latch_a     = (state == EXPECT_A);
            pair_formed = (state == EXPECT_B);
        end
    end

    // A holding register, cleared by reset and loaded on the A sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            held_a <= '0;
        end else if (latch_a) begin
            held_a <= data_in;
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO still accepts a
    // pair when the head is leaving
    always_comb begin
        pop  = pair_valid && pair_ready && !flush;
        push = pair_formed && ((level != FULL_LVL) || pop);
        drop = pair_formed && !push;
    end

    // Pair storage; data only, so no reset is needed here
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= {held_a, data_in};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head pair presentation, forced to zero while the FIFO is empty
    always_comb begin
        head       = mem[rd_ptr];
        pair_valid = (level != '0);
        a_out      = pair_valid ? head[2*WIDTH-1:WIDTH] : '0;
        b_out      = pair_valid ? head[WIDTH-1:0]       : '0;
    end

endmodule

// File: tb/tb_butterfly_pair_reader.sv
// Testbench for butterfly_pair_reader: directed scenarios plus random
// traffic, all compared every cycle against a queue-based pair model.
module tb_butterfly_pair_reader;

    localparam int WIDTH      = 32;
    localparam int FIFO_DEPTH = 4;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [WIDTH-1:0]              data_in = '0;
    logic                          valid_in = 1'b0;
    logic                          flush = 1'b0;
    logic [WIDTH-1:0]              a_out;
    logic [WIDTH-1:0]              b_out;
    logic                          pair_valid;
    logic                          pair_ready = 1'b0;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending half pair, queue of {A,B}, sticky flag
    bit               m_have_a = 0;
    logic [WIDTH-1:0] m_held   = '0;
    logic [63:0]      m_q[$];
    bit               m_ovf    = 0;

    butterfly_pair_reader #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .flush(flush), .a_out(a_out), .b_out(b_out), .pair_valid(pair_valid),
        .pair_ready(pair_ready), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                        input logic f = 1'b0, input logic rn = 1'b1);
        bit popped;
        valid_in   = v;
        data_in    = d;
        pair_ready = r;
        flush      = f;
        rst        = rn;
        @(posedge clk);
        if (!rn || f) begin
            m_have_a = 0;
            m_q.delete();
            m_ovf = 0;
            if (!rn) m_held = '0;
        end else begin
            popped = (m_q.size() > 0) && r;
            if (popped) void'(m_q.pop_front());
            if (v) begin
                if (!m_have_a) begin
                    m_held   = d;
                    m_have_a = 1;
                end else begin
                    if (m_q.size() < FIFO_DEPTH) m_q.push_back({m_held, d});
                    else m_ovf = 1;
                    m_have_a = 0;
                end
            end
        end
        #1;
        chk("level", 64'(level), 64'(m_q.size()));
        chk("pair_valid", 64'(pair_valid), 64'(m_q.size() > 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (m_q.size() > 0) begin
            chk("a_out", 64'(a_out), 64'(m_q[0][63:32]));
            chk("b_out", 64'(b_out), 64'(m_q[0][31:0]));
        end else begin
            chk("a_out_zero", 64'(a_out), 64'd0);
            chk("b_out_zero", 64'(b_out), 64'd0);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 32'hdead, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset with flush and valid asserted: reset wins
        do_reset();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Pair and latency
        step(1, 1, 1);
        chk("lat_no_pair_after_a", 64'(pair_valid), 64'd0);
        step(1, 2, 1);
        chk("lat_valid", 64'(pair_valid), 64'd1);
        chk("lat_pair", {32'(a_out), 32'(b_out)}, {32'd1, 32'd2});
        step(0, 0, 1);
        chk("lat_drained", 64'(level), 64'd0);

        // Gap tolerance
        step(1, 32'h10, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h99, 1);
            chk("gap_no_pair", 64'(pair_valid), 64'd0);
        end
        step(1, 32'h20, 1);
        chk("gap_pair", {32'(a_out), 32'(b_out)}, {32'h10, 32'h20});
        step(0, 0, 1);

        // Backpressure and ordering
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, 32'(i), 0);
        chk("bp_level", 64'(level), 64'd4);
        chk("bp_head", {32'(a_out), 32'(b_out)}, {32'd1, 32'd2});
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", {32'(a_out), 32'(b_out)}, {32'(2*i+1), 32'(2*i+2)});
            step(0, 0, 1);
        end
        chk("bp_ovf", 64'(overflow), 64'd0);

        // Overflow
        do_reset();
        for (int i = 1; i <= 10; i++) step(1, 32'(i), 0);
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", {32'(a_out), 32'(b_out)}, {32'd1, 32'd2});
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("ovf_last", {32'(a_out), 32'(b_out)}, {32'd7, 32'd8});
        step(0, 0, 1);
        chk("ovf_empty", 64'(level), 64'd0);

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 1; i <= 9; i++) step(1, 32'(i), 0);
        step(1, 10, 1);
        chk("full_pp_level", 64'(level), 64'd4);
        chk("full_pp_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("full_pp_last", {32'(a_out), 32'(b_out)}, {32'd9, 32'd10});
        step(0, 0, 1);

        // Mid-pair reset discards half pair
        do_reset();
        step(1, 5, 1);
        step(1, 5, 1, 1'b0, 1'b0);
        step(1, 6, 1);
        step(1, 7, 1);
        chk("rst_mid_pair", {32'(a_out), 32'(b_out)}, {32'd6, 32'd7});
        step(0, 0, 1);

        // Mid-pair flush after an overflow
        for (int i = 1; i <= 10; i++) step(1, 32'(i), 0);
        step(1, 5, 0);
        step(1, 5, 1, 1'b1);
        chk("flush_ovf_clr", 64'(overflow), 64'd0);
        chk("flush_empty", 64'(level), 64'd0);
        step(1, 6, 1);
        step(1, 7, 1);
        chk("flush_mid_pair", {32'(a_out), 32'(b_out)}, {32'd6, 32'd7});
        step(0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(9, 0) < 7), $urandom(), ($urandom_range(3, 0) < 2),
                 ($urandom_range(99, 0) == 0), ($urandom_range(199, 0) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
